serial_link: RTL and testbench

- Byte-wide asynchronous serial link: one transmitter path and one receiver path sharing one clock and reset.
- TX serialises a loaded byte into a framed bit stream. RX, when enabled, recovers bytes from an incoming line.
- Sits between parallel logic and a single-wire serial line; a back-to-back TX→RX connection is the reference use case.

---
 rtl/serial_link_pkg.sv | 25 ++
 rtl/serial_link_rx.sv | 123 ++++++++++++
 rtl/serial_link_tx.sv | 92 +++++++++
 rtl/serial_link.sv | 65 ++++++
 tb/tb_serial_link.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// ============================================================================
// serial_link_pkg : shared defaults, line levels and FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_link_pkg;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_W       = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } link_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_link_rx.sv
// ============================================================================
// serial_link_rx : framed serial receiver with mid-bit sampling and stop check
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_link_rx
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              line_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  link_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              w_tick;

  assign w_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (en_i && (line_i == START_BIT)) begin
          state_d = ST_START;
          // The detect cycle counts toward the half-bit wait, so every
          // sample lands CLKS_PER_BIT/2 cycles after its bit edge.
          cnt_d   = CNT_W'(1);
        end
      end
      ST_START: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = (line_i == START_BIT) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (w_tick) begin
          cnt_d   = '0;
          shift_d = {line_i, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            data_d  = {line_i, shift_q[DATA_W-1:1]};
            valid_d = 1'b1;
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (w_tick) begin
          ferr_d  = (line_i != STOP_BIT);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

`default_nettype wire

// File: rtl/serial_link_tx.sv
// ============================================================================
// serial_link_tx : framed serial transmitter (start, DATA_W bits LSB first, stop)
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_link_tx
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              serial_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  link_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              w_tick;

  assign w_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = w_tick ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (load_i) begin
          shift_d = data_i;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    serial_o = IDLE_LINE;
    busy_o   = 1'b1;
    case (state_q)
      ST_START: serial_o = START_BIT;
      ST_DATA:  serial_o = shift_q[0];
      ST_STOP:  serial_o = STOP_BIT;
      default:  busy_o   = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_link.sv
// ============================================================================
// serial_link : independent serial TX and RX paths; SERIAL_LINK_LOOPBACK_EN
// ties the RX input to tx_serial_out internally.   Rev 1.0
// ============================================================================
`default_nettype none

module serial_link
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_serial_out,
  output logic              tx_state,
  input  logic              rx_enable,
  input  logic              rx_serial_in,
  output logic              rx_state,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              rx_frame_err
);

  logic w_rx_line;

`ifdef SERIAL_LINK_LOOPBACK_EN
  logic w_unused_rx_pin;
  assign w_unused_rx_pin = rx_serial_in;
  assign w_rx_line       = tx_serial_out;
`else
  assign w_rx_line       = rx_serial_in;
`endif

  serial_link_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_tx (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (load),
    .data_i   (data_in),
    .serial_o (tx_serial_out),
    .busy_o   (tx_state)
  );

  serial_link_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (reset),
    .en_i        (rx_enable),
    .line_i      (w_rx_line),
    .busy_o      (rx_state),
    .data_o      (data_out),
    .valid_o     (rx_valid),
    .frame_err_o (rx_frame_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_serial_link.sv
// ============================================================================
// tb_serial_link : back-to-back TX->RX bench for serial_link (default build)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_link;

  typedef struct {
    logic [7:0] d;
    logic [9:0] f;     // expected frame, f[9] transmitted first
    bit         inj;
    bit         serr;
    bit         abrt;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       rx_enable;
  logic       ovr;
  logic       ovr_val;
  wire        rx_line;
  wire        tx_serial_out;
  wire        tx_state;
  wire        rx_state;
  wire [7:0]  data_out;
  wire        rx_valid;
  wire        rx_frame_err;

  int         n_vec;
  int         n_bad;
  int         n_valid_mon;
  logic [7:0] prev_rx;
  vec_t       tbl [10];

  assign rx_line = ovr ? ovr_val : tx_serial_out;

  serial_link dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .data_in       (data_in),
    .tx_serial_out (tx_serial_out),
    .tx_state      (tx_state),
    .rx_enable     (rx_enable),
    .rx_serial_in  (rx_line),
    .rx_state      (rx_state),
    .data_out      (data_out),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) n_valid_mon++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start bit, data LSB first, stop bit.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic [9:0] f;
    f[9] = 1'b0;
    f[0] = 1'b1;
    for (int j = 0; j < 8; j++) f[8-j] = d[j];
    return f;
  endfunction

  // Runs one frame (i = cycles after the load-sampling edge) and checks the
  // line at every mid-bit, TX busy, RX valid timing/data and framing error.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] expf,
                           input bit started, input bit inject,
                           input bit stop_err, input bit abort_rx);
    int         vcyc, vcnt, ecyc, ecnt;
    logic [7:0] d84, d85;
    logic       st41;
    vcyc = -1; vcnt = 0; ecyc = -1; ecnt = 0;
    d84 = '0; d85 = '0; st41 = 1'b1;
    if (!started) begin
      load    = 1'b1;
      data_in = d;
      tick();
      load    = 1'b0;
    end
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) tick();
      if (i < 100 && (i % 10) == 5)
        check($sformatf("tx_bit%0d_%02h", i / 10, d), int'(tx_serial_out), int'(expf[9 - i / 10]));
      if (rx_valid) begin
        vcnt++;
        if (vcyc < 0) vcyc = i;
      end
      if (rx_frame_err) begin
        ecnt++;
        if (ecyc < 0) ecyc = i;
      end
      if (i == 84) d84 = data_out;
      if (i == 85) d85 = data_out;
      if (i == 41) st41 = rx_state;
      if (i == 0)   check("tx_state_start", int'(tx_state), 1);
      if (i == 99)  check("tx_state_stop", int'(tx_state), 1);
      if (i == 100) check("tx_state_idle", int'(tx_state), 0);
      if (inject && i == 40) begin load = 1'b1; data_in = 8'hFF; end
      if (inject && i == 41) load = 1'b0;
      if (inject && i == 60) data_in = 8'($urandom);
      if (stop_err && i == 90) begin ovr = 1'b1; ovr_val = 1'b0; end
      if (stop_err && i == 95) ovr = 1'b0;
      if (abort_rx && i == 40) rx_enable = 1'b0;
    end
    if (abort_rx) begin
      check("abort_valid_cnt", vcnt, 0);
      check("abort_data_held", int'(data_out), int'(prev_rx));
      check("abort_rx_state", int'(st41), 0);
      rx_enable = 1'b1;
    end else begin
      check($sformatf("rx_valid_cycle_%02h", d), vcyc, 85);
      check("rx_valid_cnt", vcnt, 1);
      check("data_held_before", int'(d84), int'(prev_rx));
      check($sformatf("data_out_%02h", d), int'(d85), int'(d));
      prev_rx = d;
    end
    check("frame_err_cnt", ecnt, stop_err ? 1 : 0);
    if (stop_err) check("frame_err_cycle", ecyc, 95);
  endtask

  initial begin
    int n0;
    n_vec = 0; n_bad = 0; n_valid_mon = 0;
    prev_rx = 8'h00;
    ovr = 1'b0; ovr_val = 1'b1;

    tbl[0] = '{8'h9D, 10'b0101110011, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h45, 10'b0101000101, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 10'b0000000001, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 10'b0111111111, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'hA5, 10'b0101001011, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 10'b0100000001, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 10'b0000000011, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'h3C, 10'b0001111001, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'hC6, 10'b0011000111, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{8'hE7, 10'b0111001111, 1'b0, 1'b0, 1'b1};

    // Reset held with load asserted: nothing may start.
    reset = 1'b0; load = 1'b1; data_in = 8'h9D; rx_enable = 1'b1;
    repeat (3) tick();
    check("rst_tx_line", int'(tx_serial_out), 1);
    check("rst_tx_state", int'(tx_state), 0);
    check("rst_rx_state", int'(rx_state), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(rx_frame_err), 0);
    load = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_line", int'(tx_serial_out), 1);
    check("post_rst_tx_state", int'(tx_state), 0);

    for (int k = 0; k < 10; k++) begin
      run_frame(tbl[k].d, tbl[k].f, 1'b0, tbl[k].inj, tbl[k].serr, tbl[k].abrt);
      repeat (k % 3) tick();
    end

    // False start: 3-cycle low glitch.
    n0 = n_valid_mon;
    ovr = 1'b1; ovr_val = 1'b0;
    repeat (3) tick();
    check("fs_rx_busy", int'(rx_state), 1);
    ovr = 1'b0;
    repeat (3) tick();
    check("fs_rx_idle", int'(rx_state), 0);
    repeat (20) tick();
    check("fs_no_valid", n_valid_mon - n0, 0);
    check("fs_data_held", int'(data_out), int'(prev_rx));

    // Back-to-back frames with load held through the first one.
    load = 1'b1; data_in = 8'h5A;
    tick();
    check("b2b_start_line", int'(tx_serial_out), 0);
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 50) data_in = 8'hC3;
      if (i == 90) check("b2b_first_byte", int'(data_out), 8'h5A);
      if (i == 100) begin
        check("b2b_gap_state", int'(tx_state), 0);
        check("b2b_gap_line", int'(tx_serial_out), 1);
      end
      if (i == 101) begin
        check("b2b_restart_state", int'(tx_state), 1);
        check("b2b_restart_line", int'(tx_serial_out), 0);
        load = 1'b0;
      end
    end
    prev_rx = 8'h5A;
    run_frame(8'hC3, frame_of(8'hC3), 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame aborts both paths immediately.
    load = 1'b1; data_in = 8'h77;
    tick();
    load = 1'b0;
    repeat (50) tick();
    reset = 1'b0;
    #1;
    check("midrst_line", int'(tx_serial_out), 1);
    check("midrst_tx_state", int'(tx_state), 0);
    check("midrst_rx_state", int'(rx_state), 0);
    check("midrst_data_out", int'(data_out), 0);
    repeat (2) tick();
    reset = 1'b1;
    n0 = n_valid_mon;
    repeat (110) tick();
    check("midrst_no_valid", n_valid_mon - n0, 0);
    check("midrst_idle_line", int'(tx_serial_out), 1);
    prev_rx = 8'h00;

    // Randomised frames against the frame model.
    for (int k = 0; k < 20; k++) begin
      logic [7:0] rd;
      bit         rinj;
      repeat ($urandom_range(0, 15)) tick();
      rd   = 8'($urandom);
      rinj = 1'($urandom_range(0, 1));
      run_frame(rd, frame_of(rd), 1'b0, rinj, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
